// File: rtl/h80_uart_rx_if.sv
// Receive-side bus interface of the H80 UART: byte pops and sticky error flags.
interface h80_uart_rx_if;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  // Bus slave side: issues pops and error clears.
  modport master (
    output rd_en, clr_err,
    input  rd_data, rx_valid, overrun, frame_err
  );

  // Receiver side: supplies buffered bytes and status.
  modport slave (
    input  rd_en, clr_err,
    output rd_data, rx_valid, overrun, frame_err
  );
endinterface

// File: rtl/h80_uart_rx.sv
// 8N1 UART receiver with a small first-word-fall-through byte FIFO.
module h80_uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_FREQ  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        uart_rxp,
  h80_uart_rx_if.slave bus
);
  localparam int DIV  = (CLK_FREQ + UART_FREQ/2) / UART_FREQ;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push_q;   // one-cycle pulse: shreg holds a good byte
  logic        ferr_q;   // one-cycle pulse: stop bit was low
  logic [1:0]  sync_q;
  logic        rxs;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic        full, pop, do_push, ovf_evt;
  logic        rx_valid_q, overrun_q, frame_err_q;

  // Two-flop synchroniser, preset high so reset release never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], uart_rxp};

  assign rxs = sync_q[1];

  // Frame FSM: mid-bit sampling driven by the baud counter; outputs are registered pulses.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state)
        IDLE: if (!rxs) begin
          baud_cnt <= CW'(HALF - 1);
          state    <= START;
        end
        START: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else if (rxs) state <= IDLE;  // false start: line went back high
          else begin
            baud_cnt <= CW'(DIV - 1);
            bit_idx  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else begin
            shreg    <= {rxs, shreg[7:1]};
            baud_cnt <= CW'(DIV - 1);
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else if (rxs) begin
            push_q <= 1'b1;
            state  <= IDLE;
          end else begin
            ferr_q <= 1'b1;
            state  <= BREAK;
          end
        end
        BREAK: if (rxs) state <= IDLE;  // wait out a held-low line
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = bus.rd_en & rx_valid_q;
  assign do_push = push_q & (~full | pop);
  assign ovf_evt = push_q & full & ~pop;

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (do_push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !do_push) count_nxt = count - 1'b1;
  end

  // FIFO pointers, occupancy and registered not-empty flag.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      rx_valid_q <= (count_nxt != '0);
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge sysclk)
    if (do_push) mem[wr_ptr] <= shreg;

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= (overrun_q & ~bus.clr_err) | ovf_evt;
      frame_err_q <= (frame_err_q & ~bus.clr_err) | ferr_q;
    end
  end

  assign bus.rd_data   = rx_valid_q ? mem[rd_ptr] : 8'h00;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule
